// File: rtl/switch_rx_side_pkg.sv
// switch_rx_side_pkg
//   Shared defaults and the handshake FSM encodings for the receive half
//   of a switch side.
//   No ports: imported by rx_channel and switch_rx_side.
package switch_rx_side_pkg;

    localparam int AW_DEV_DEF     = 2;
    localparam int N_DEV_DEF      = 1 << AW_DEV_DEF;
    localparam int DW_DEF         = 4;
    localparam int DEPTH_DEF      = 2;
    localparam int FULL_SLACK_DEF = 2;

    // Per-channel delivery FSM encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_REL  = 2'd2;

endpackage

// File: rtl/switch_rx_side_if.sv
// switch_rx_side_if
//   Crossbar-side bus between the opposite side's sender and this receive
//   half.
//   int_wen : one-hot write enables, bit k writes channel k
//   int_dat : write data shared by all channels
//   full    : per-channel almost-full flags back to the sender's arbiter
//   ovf     : per-channel sticky overflow flags
//   master = sending side, slave = switch_rx_side.
interface switch_rx_side_if #(
    parameter int N_DEV = switch_rx_side_pkg::N_DEV_DEF,
    parameter int DW    = switch_rx_side_pkg::DW_DEF
);
    logic [N_DEV-1:0] int_wen;
    logic [DW-1:0]    int_dat;
    logic [N_DEV-1:0] full;
    logic [N_DEV-1:0] ovf;

    modport master (
        output int_wen,
        output int_dat,
        input  full,
        input  ovf
    );

    modport slave (
        input  int_wen,
        input  int_dat,
        output full,
        output ovf
    );
endinterface

// File: rtl/switch_rx_side_rx_channel.sv
// rx_channel
//   One destination channel: a 2^DEPTH-entry FIFO fed by the crossbar,
//   a 4-phase validrx/ackrx delivery FSM, an almost-full flag and a
//   sticky overflow flag.
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low reset
//   wen_i      write enable for this channel
//   dat_i      write data
//   dat_o      data presented to the device (holds last value)
//   validrx_o  4-phase request
//   ackrx_i    4-phase acknowledge from the device
//   full_o     free entries <= FULL_SLACK
//   ovf_o      sticky: a write was dropped because the FIFO was full
module rx_channel
    import switch_rx_side_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int FULL_SLACK = FULL_SLACK_DEF
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wen_i,
    input  logic [DW-1:0] dat_i,
    output logic [DW-1:0] dat_o,
    output logic          validrx_o,
    input  logic          ackrx_i,
    output logic          full_o,
    output logic          ovf_o
);

    localparam int          N_ENT   = 1 << DEPTH;
    localparam logic [DEPTH:0] CNT_MAX = (DEPTH+1)'(N_ENT);
    localparam logic [DEPTH:0] SLACK_C = (DEPTH+1)'(FULL_SLACK);

    logic [DW-1:0]    mem [N_ENT];
    logic [DEPTH-1:0] wr_ptr;
    logic [DEPTH-1:0] rd_ptr;
    logic [DEPTH:0]   count;
    logic [1:0]       state;
    logic             pop;
    logic             push;

    // A pop in the same cycle frees a slot, so a write into a full FIFO
    // is still accepted on the pop cycle.
    always_comb begin
        pop  = (state == ST_IDLE) && (count != '0);
        push = wen_i && ((count != CNT_MAX) || pop);
    end

    assign full_o = (CNT_MAX - count) <= SLACK_C;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= dat_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            state     <= ST_IDLE;
            dat_o     <= '0;
            validrx_o <= 1'b0;
            ovf_o     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + DEPTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (DEPTH+1)'(1);
                2'b01:   count <= count - (DEPTH+1)'(1);
                default: count <= count;
            endcase

            if (wen_i && !push) begin
                ovf_o <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        dat_o     <= mem[rd_ptr];
                        validrx_o <= 1'b1;
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (ackrx_i) begin
                        validrx_o <= 1'b0;
                        state     <= ST_REL;
                    end
                end
                ST_REL: begin
                    if (!ackrx_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    validrx_o <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/switch_rx_side.sv
// switch_rx_side
//   Receive half of a switch side: four rx_channel instances, one per
//   destination device. Fans out the one-hot write enables and the shared
//   write data, and collects the full/overflow flags onto the bus.
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   bus (slave)            int_wen/int_dat in, full/ovf out
//   dat_o_k, validrx_k     data and 4-phase request to device k
//   ackrx_k                4-phase acknowledge from device k
module switch_rx_side
    import switch_rx_side_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int FULL_SLACK = FULL_SLACK_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    switch_rx_side_if.slave  bus,
    output logic [DW-1:0]    dat_o_0,
    output logic [DW-1:0]    dat_o_1,
    output logic [DW-1:0]    dat_o_2,
    output logic [DW-1:0]    dat_o_3,
    output logic             validrx_0,
    output logic             validrx_1,
    output logic             validrx_2,
    output logic             validrx_3,
    input  logic             ackrx_0,
    input  logic             ackrx_1,
    input  logic             ackrx_2,
    input  logic             ackrx_3
);

    localparam int N_DEV = N_DEV_DEF;

    logic [DW-1:0]    dat_w [N_DEV];
    logic [N_DEV-1:0] vr_w;
    logic [N_DEV-1:0] ack_w;
    logic [N_DEV-1:0] full_w;
    logic [N_DEV-1:0] ovf_w;

    assign ack_w = {ackrx_3, ackrx_2, ackrx_1, ackrx_0};

    for (genvar k = 0; k < N_DEV; k++) begin : g_ch
        rx_channel #(
            .DW         (DW),
            .DEPTH      (DEPTH),
            .FULL_SLACK (FULL_SLACK)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .wen_i     (bus.int_wen[k]),
            .dat_i     (bus.int_dat),
            .dat_o     (dat_w[k]),
            .validrx_o (vr_w[k]),
            .ackrx_i   (ack_w[k]),
            .full_o    (full_w[k]),
            .ovf_o     (ovf_w[k])
        );
    end

    assign bus.full = full_w;
    assign bus.ovf  = ovf_w;

    assign dat_o_0   = dat_w[0];
    assign dat_o_1   = dat_w[1];
    assign dat_o_2   = dat_w[2];
    assign dat_o_3   = dat_w[3];
    assign validrx_0 = vr_w[0];
    assign validrx_1 = vr_w[1];
    assign validrx_2 = vr_w[2];
    assign validrx_3 = vr_w[3];

endmodule
